// File: rtl/uart_ram_pkg.sv
// Shared types and constants for the on-chip RAM to UART byte-stream reader.
package uart_ram_pkg;

    localparam int RAM_DEPTH      = 5120;
    localparam int RAM_ADDR_W     = 13;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_LEN_W     = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Little-endian byte lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/word_to_byte_unpacker.sv
// Holds one 32-bit word and presents its low i_count bytes, lowest first, on a
// registered valid/ready byte stream.
module word_to_byte_unpacker
    import uart_ram_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [2:0]  i_count,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [2:0]  r_cnt;
    logic        r_valid;
    logic [7:0]  r_data;
    logic        w_fire;
    logic        w_last;
    logic [1:0]  w_next_idx;

    assign w_fire     = r_valid & i_ready;
    assign w_last     = ({1'b0, r_idx} == (r_cnt - 3'd1));
    assign w_next_idx = r_idx + 2'd1;

    // Word buffer, byte index and the registered output byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word  <= 32'd0;
            r_idx   <= 2'd0;
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
            r_data  <= 8'd0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= 2'd0;
            r_cnt   <= i_count;
            r_valid <= 1'b1;
            r_data  <= word_byte(i_word, 2'd0);
        end else if (w_fire) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx  <= w_next_idx;
                r_data <= word_byte(r_word, w_next_idx);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = w_last;

endmodule

// File: rtl/onchip_ram_stream_reader.sv
// Avalon-MM read initiator: fetches words from on-chip RAM and streams their bytes,
// little-endian, to the UART TX path.
module onchip_ram_stream_reader
    import uart_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int LEN_W  = BYTE_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [LEN_W-1:0]  i_byte_len,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_chipselect,
    output logic              o_avm_write,
    output logic [3:0]        o_avm_byteenable,
    output logic              o_avm_clken,
    input  logic [31:0]       i_avm_readdata,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_busy;
    logic              r_done;
    logic              r_cs;
    logic              w_load;
    logic              w_clear;
    logic              w_fire;
    logic              w_last;
    logic              w_tx_valid;
    logic [2:0]        w_count;

    assign w_fire  = w_tx_valid & i_tx_ready;
    assign w_clear = i_abort & (r_state != IDLE);
    assign w_count = (r_remaining > LEN_W'(BYTES_PER_WORD)) ? 3'd4 : r_remaining[2:0];

    // Next-state decode; abort is ignored in IDLE so a simultaneous start wins.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (i_byte_len != {LEN_W{1'b0}}) ? READ : FINISH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            READ: begin
                w_next_state = i_abort ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = EMIT;
                    w_load       = 1'b1;
                end
            end
            EMIT: begin
                if (i_abort) begin
                    w_next_state = IDLE;
                end else if (w_fire && (r_remaining == LEN_W'(1))) begin
                    w_next_state = FINISH;
                end else if (w_fire && w_last) begin
                    w_next_state = READ;
                end else begin
                    w_next_state = EMIT;
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, address/length counters and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_remaining <= {LEN_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cs        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == READ) || (w_next_state == CAPTURE) ||
                       (w_next_state == EMIT);
            r_done  <= (w_next_state == FINISH);
            r_cs    <= (w_next_state == READ);
            if ((r_state == IDLE) && i_start) begin
                r_addr      <= i_start_addr;
                r_remaining <= i_byte_len;
            end else if ((r_state == EMIT) && w_fire) begin
                r_remaining <= r_remaining - LEN_W'(1);
                // DEPTH is not a power of two, so wrap by compare rather than mask.
                if (w_last) begin
                    r_addr <= (r_addr == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}}
                                                             : r_addr + ADDR_W'(1);
                end
            end
        end
    end

    word_to_byte_unpacker u_unpacker (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_word  (i_avm_readdata),
        .i_count (w_count),
        .i_ready (i_tx_ready),
        .o_valid (w_tx_valid),
        .o_data  (o_tx_data),
        .o_last  (w_last)
    );

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_avm_address    = r_addr;
    assign o_avm_chipselect = r_cs;
    assign o_avm_write      = 1'b0;
    assign o_avm_byteenable = 4'hF;
    assign o_avm_clken      = 1'b1;
    assign o_tx_valid       = w_tx_valid;

endmodule
